// File: rtl/button_filter_multi.sv
// button_filter_multi: per-channel two-flop synchroniser, symmetric debounce,
// press/release strobes and a one-shot long-press strobe for a bank of buttons.
// Optional feature macro: BUTTON_FILTER_AUTO_REPEAT_EN (auto-repeat Press after LongPress).
module button_filter_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] State,
    output logic [CHANNELS-1:0] Level,
    output logic [CHANNELS-1:0] Press,
    output logic [CHANNELS-1:0] Release,
    output logic [CHANNELS-1:0] LongPress
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // Reject configurations that would break the counter width arithmetic.
    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES ||
        REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_filter_multi: invalid parameter set");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [1:0]    sync_q;
        logic          s;
        logic          level_q, level_d;
        logic [DW-1:0] db_q, db_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          fired_q, fired_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          repeat_hit;

        assign s = sync_q[1];

        // Two-flop synchroniser for the asynchronous raw input.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], State[i]};
            end
        end

`ifdef BUTTON_FILTER_AUTO_REPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES);
        localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rpt_q, rpt_d;

        // Repeat phase counter; only runs once the long press has fired.
        always_comb begin
            rpt_d      = rpt_q;
            repeat_hit = 1'b0;
            if (!level_q || !fired_q) begin
                rpt_d = '0;
            end else if (rpt_q == RPT_LAST) begin
                rpt_d      = '0;
                repeat_hit = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end

        // Repeat counter register.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                rpt_q <= '0;
            end else begin
                rpt_q <= rpt_d;
            end
        end
`else
        assign repeat_hit = 1'b0;
`endif

        // Debounce, hold timing and strobe generation.
        always_comb begin
            level_d   = level_q;
            db_d      = db_q;
            hold_d    = hold_q;
            fired_d   = fired_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;

            // Any agreeing sample restarts the full window.
            if (s != level_q) begin
                if (db_q == DB_LAST) begin
                    level_d   = s;
                    db_d      = '0;
                    press_d   = s;
                    release_d = ~s;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end else begin
                db_d = '0;
            end

            // level_q is still 0 on the rising edge, so the hold count starts fresh.
            if (!level_q) begin
                hold_d  = '0;
                fired_d = 1'b0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end

            if (level_q && !fired_q && hold_q == HOLD_LAST) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end

            // A repeat on the same edge as a debounced fall is dropped.
            if (repeat_hit && level_d) begin
                press_d = 1'b1;
            end
        end

        // Channel state and registered strobes.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                level_q   <= 1'b0;
                db_q      <= '0;
                hold_q    <= '0;
                fired_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                level_q   <= level_d;
                db_q      <= db_d;
                hold_q    <= hold_d;
                fired_q   <= fired_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign Level[i]     = level_q;
        assign Press[i]     = press_q;
        assign Release[i]   = release_q;
        assign LongPress[i] = long_q;
    end

endmodule

// File: tb/tb_button_filter_multi.sv
// Self-checking bench for button_filter_multi: directed scenarios with literal
// timing expectations plus randomized stimulus checked every cycle against a
// behavioural model built from sample streaks and press timestamps.
module tb_button_filter_multi;

    localparam int CH = 4;
    localparam int D  = 8;
    localparam int H  = 32;
    localparam int R  = 16;

    logic          CLK;
    logic          RST;
    logic [CH-1:0] State;
    logic [CH-1:0] Level;
    logic [CH-1:0] Press;
    logic [CH-1:0] Release;
    logic [CH-1:0] LongPress;

    int n_tests;
    int n_fail;
    int cyc;

    // Model state
    bit          m_s1[CH];
    bit          m_s2[CH];
    bit          m_lvl[CH];
    int          m_streak[CH];
    int          m_rise[CH];
    logic [CH-1:0] exp_level, exp_press, exp_release, exp_long;

    // Observed pulse totals (DUT and model)
    int dut_press_cnt[CH];
    int dut_rel_cnt[CH];
    int dut_long_cnt[CH];
    int mod_press_cnt[CH];

    button_filter_multi #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .State    (State),
        .Level    (Level),
        .Press    (Press),
        .Release  (Release),
        .LongPress(LongPress)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit sig(input int kind, input int ch);
        case (kind)
            0:       return Press[ch];
            1:       return Release[ch];
            2:       return LongPress[ch];
            default: return Level[ch];
        endcase
    endfunction

    // Count edges until the chosen output goes high; -1 if the bound expires.
    task automatic wait_edge(input int kind, input int ch, input int limit, output int k);
        k = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge CLK);
            #1;
            if (sig(kind, ch)) begin
                k = n;
                return;
            end
        end
    endtask

    // Behavioural model plus per-cycle comparison.
    initial begin : model
        for (int c = 0; c < CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_streak[c] = 0; m_rise[c] = 0;
            dut_press_cnt[c] = 0; dut_rel_cnt[c] = 0; dut_long_cnt[c] = 0;
            mod_press_cnt[c] = 0;
        end
        exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
            exp_press = '0; exp_release = '0; exp_long = '0;
            if (RST) begin
                for (int c = 0; c < CH; c++) begin
                    m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_streak[c] = 0;
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    bit s;
                    bit prev;
                    bit nl;
                    s    = m_s2[c];
                    prev = m_lvl[c];
                    nl   = prev;
                    // D consecutive disagreeing samples flip the level.
                    if (s != prev) begin
                        m_streak[c]++;
                        if (m_streak[c] == D) begin
                            nl = s;
                            m_streak[c] = 0;
                        end
                    end else begin
                        m_streak[c] = 0;
                    end
                    if (nl && !prev) begin
                        exp_press[c] = 1'b1;
                        m_rise[c] = cyc;
                    end
                    if (!nl && prev) exp_release[c] = 1'b1;
                    if (prev && (cyc - m_rise[c] == H)) exp_long[c] = 1'b1;
`ifdef BUTTON_FILTER_AUTO_REPEAT_EN
                    if (prev && nl && (cyc - m_rise[c] > H) &&
                        ((cyc - m_rise[c] - H) % R == 0)) exp_press[c] = 1'b1;
`endif
                    m_lvl[c] = nl;
                    m_s2[c]  = m_s1[c];
                    m_s1[c]  = State[c];
                end
            end
            for (int c = 0; c < CH; c++) exp_level[c] = m_lvl[c];
            #1;
            check("level", int'(Level), int'(exp_level));
            check("press", int'(Press), int'(exp_press));
            check("release", int'(Release), int'(exp_release));
            check("longpress", int'(LongPress), int'(exp_long));
            for (int c = 0; c < CH; c++) begin
                if (Press[c])     dut_press_cnt[c]++;
                if (Release[c])   dut_rel_cnt[c]++;
                if (LongPress[c]) dut_long_cnt[c]++;
                if (exp_press[c]) mod_press_cnt[c]++;
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : stim
        int k;
        int p0, r0, l0, mp0;
        int run[CH];
        logic [CH-1:0] val;
        int rst_left;

        n_tests = 0;
        n_fail  = 0;
        RST   = 1'b1;
        State = '0;
        repeat (3) @(negedge CLK);
        #1;
        check("reset_outputs", int'({Level, Press, Release, LongPress}), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Clean press on channel 0
        State[0] = 1'b1;
        wait_edge(0, 0, 40, k);
        check("clean_press_latency", k, 10);
        check("clean_level_with_press", int'(Level[0]), 1);
        @(posedge CLK);
        #1;
        check("press_one_cycle", int'(Press[0]), 0);
        wait_edge(2, 0, 60, k);
        check("longpress_latency", k, 31);
        check("other_channels_idle", int'(Level[3:1]), 0);
        repeat (58) @(negedge CLK);
        State[0] = 1'b0;
        wait_edge(1, 0, 40, k);
        check("clean_release_latency", k, 10);
        repeat (20) @(negedge CLK);

        // Bouncy press on channel 1: 5 high / 2 low, then held high
        p0 = dut_press_cnt[1];
        for (int i = 0; i < 35; i++) begin
            @(negedge CLK);
            State[1] = ((i % 7) < 5);
        end
        repeat (2) @(negedge CLK);
        check("bounce_no_press", dut_press_cnt[1] - p0, 0);
        check("bounce_level_low", int'(Level[1]), 0);
        State[1] = 1'b1;
        wait_edge(0, 1, 40, k);
        check("bounce_press_latency", k, 10);
        @(negedge CLK);
        State[1] = 1'b0;
        repeat (30) @(negedge CLK);

        // Short press on channel 2
        p0 = dut_press_cnt[2];
        r0 = dut_rel_cnt[2];
        l0 = dut_long_cnt[2];
        State[2] = 1'b1;
        wait_edge(0, 2, 40, k);
        check("short_press_latency", k, 10);
        repeat (10) @(negedge CLK);
        State[2] = 1'b0;
        wait_edge(1, 2, 40, k);
        check("short_release_latency", k, 10);
        repeat (40) @(negedge CLK);
        check("short_press_count", dut_press_cnt[2] - p0, 1);
        check("short_release_count", dut_rel_cnt[2] - r0, 1);
        check("short_no_longpress", dut_long_cnt[2] - l0, 0);

        // Simultaneous press on channels 0 and 3
        State[0] = 1'b1;
        State[3] = 1'b1;
        wait_edge(0, 0, 40, k);
        check("simul_press_latency", k, 10);
        check("simul_press_ch3", int'(Press[3]), 1);
        @(negedge CLK);
        State[0] = 1'b0;
        State[3] = 1'b0;
        repeat (30) @(negedge CLK);

        // Reset mid-debounce with channel 2 held high
        State[2] = 1'b1;
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("reset_mid_outputs", int'({Level, Press, Release, LongPress}), 0);
        repeat (3) @(negedge CLK);
        check("reset_held_outputs", int'({Level, Press, Release, LongPress}), 0);
        RST = 1'b0;
        wait_edge(0, 2, 40, k);
        check("post_reset_press_latency", k, 10);
        @(negedge CLK);
        State[2] = 1'b0;
        repeat (30) @(negedge CLK);

        // Hold channel 0 for 100 sampled cycles
        p0  = dut_press_cnt[0];
        r0  = dut_rel_cnt[0];
        l0  = dut_long_cnt[0];
        mp0 = mod_press_cnt[0];
        @(negedge CLK);
        State[0] = 1'b1;
        repeat (100) @(negedge CLK);
        State[0] = 1'b0;
        repeat (30) @(negedge CLK);
`ifdef BUTTON_FILTER_AUTO_REPEAT_EN
        check("hold_press_count", dut_press_cnt[0] - p0, 5);
        check("hold_model_press_count", mod_press_cnt[0] - mp0, 5);
`else
        check("hold_press_count", dut_press_cnt[0] - p0, 1);
        check("hold_model_press_count", mod_press_cnt[0] - mp0, 1);
`endif
        check("hold_release_count", dut_rel_cnt[0] - r0, 1);
        check("hold_longpress_count", dut_long_cnt[0] - l0, 1);

        // Randomized traffic; every cycle is checked by the model process
        val = '0;
        for (int c = 0; c < CH; c++) run[c] = 1;
        rst_left = 0;
        repeat (5000) begin
            @(negedge CLK);
            for (int c = 0; c < CH; c++) begin
                run[c]--;
                if (run[c] <= 0) begin
                    int r;
                    val[c] = ~val[c];
                    r = $urandom_range(0, 9);
                    if (r < 4)      run[c] = $urandom_range(1, 7);
                    else if (r < 8) run[c] = $urandom_range(8, 30);
                    else            run[c] = $urandom_range(40, 110);
                end
            end
            State = val;
            if (RST) begin
                rst_left--;
                if (rst_left <= 0) RST = 1'b0;
            end else if ($urandom_range(0, 1499) == 0) begin
                RST = 1'b1;
                rst_left = $urandom_range(1, 4);
            end
        end
        RST   = 1'b0;
        State = '0;
        repeat (150) @(negedge CLK);
        check("final_levels_low", int'(Level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
